flags_ctrl: RTL

//  Sequencer for the 5-bit status-flag register {D0,CF,OF,NF,ZF}; drives its Flags/FWE inputs.

---
 rtl/flags_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/flags_ctrl.sv
// flags_ctrl: sequencer for the 5-bit status-flag register {D0,CF,OF,NF,ZF}.
//   Merges ALU flag updates and explicit flag instructions (CLC/STC/CLD/STD/CMC) into per-bit
//   write enables. On interrupt entry it saves the flags to memory, and on interrupt return it
//   restores them, using a req/ack bus handshake with a timeout.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   alu_valid/flags/mask     ALU flag update {C,O,N,Z} and the bits it affects
//   alu_chain                chained multi-byte op (ZF accumulate, optional feature)
//   fop_valid/fop            explicit flag instruction
//   save_req/restore_req     interrupt entry / return pulses
//   cur_flags                current flag register contents
//   Flags/FWE                data and per-bit load enable to the flag register
//   mem_*                    save-slot bus interface
//   busy                     CPU stall while a save/restore is in progress
//   err                      sticky bus-timeout indicator
// Configuration: define FLAGS_ZF_CHAIN_EN to make chained ALU ops AND the new ZF with the old ZF.
module flags_ctrl #(
  parameter int unsigned        ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  SAVE_ADDR = 8'hFF,
  parameter int unsigned        TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alu_valid,
  input  logic [3:0]        alu_flags,
  input  logic [3:0]        alu_mask,
  input  logic              alu_chain,
  input  logic              fop_valid,
  input  logic [2:0]        fop,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [4:0]        cur_flags,
  output logic [4:0]        Flags,
  output logic [4:0]        FWE,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSave, StRestore, StLoad} state_e;

  state_e              state_q, state_d;
  logic [4:0]          flags_q, flags_d;
  logic [4:0]          fwe_q, fwe_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic [4:0] upd_mask, upd_val, merged;
  logic       zf_new;

  // Only the low five read bits carry flags.
  logic [2:0] unused_rdata;
  assign unused_rdata = mem_rdata[7:5];

  // Combined update requested this cycle; fop overrides the ALU on CF.
  always_comb begin
    upd_mask = '0;
    upd_val  = '0;
    zf_new   = alu_flags[0];
`ifdef FLAGS_ZF_CHAIN_EN
    // Multi-byte zero test: result is zero only if every byte so far was zero.
    if (alu_chain && alu_mask[0]) zf_new = alu_flags[0] & cur_flags[0];
`endif
    if (alu_valid) begin
      upd_mask[3:0] = alu_mask;
      upd_val[3:0]  = {alu_flags[3:1], zf_new};
    end
    if (fop_valid) begin
      case (fop)
        3'b000: begin upd_mask[3] = 1'b1; upd_val[3] = 1'b0;          end
        3'b001: begin upd_mask[3] = 1'b1; upd_val[3] = 1'b1;          end
        3'b010: begin upd_mask[4] = 1'b1; upd_val[4] = 1'b0;          end
        3'b011: begin upd_mask[4] = 1'b1; upd_val[4] = 1'b1;          end
        3'b100: begin upd_mask[3] = 1'b1; upd_val[3] = ~cur_flags[3]; end
        default: ;
      endcase
    end
    merged = (upd_mask & upd_val) | (~upd_mask & cur_flags);
  end

`ifndef FLAGS_ZF_CHAIN_EN
  logic unused_chain;
  assign unused_chain = alu_chain;
`endif

  always_comb begin
    state_d     = state_q;
    fwe_d       = '0;
    flags_d     = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    timer_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (restore_req) begin
          // Same-cycle updates are dropped: the restored value overwrites everything anyway.
          state_d   = StRestore;
          mem_req_d = 1'b1;
        end else begin
          fwe_d   = upd_mask;
          flags_d = upd_val;
          if (save_req) begin
            // The saved image includes the update committed in the same cycle.
            state_d     = StSave;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = {3'b000, merged};
          end
        end
      end
      StSave, StRestore: begin
        if (mem_ack) begin
          if (state_q == StRestore) begin
            state_d = StLoad;
            fwe_d   = '1;
            flags_d = mem_rdata[4:0];
          end else begin
            state_d = StIdle;
          end
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d   = timer_q + 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = (state_q == StSave);
        end
      end
      StLoad: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d     = (state_d != StIdle);
    mem_addr_d = mem_req_d ? SAVE_ADDR : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      flags_q     <= '0;
      fwe_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      fwe_q       <= fwe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign Flags     = flags_q;
  assign FWE       = fwe_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
